// File: rtl/muldiv_pkg.sv
// Shared op and FSM encodings for the multiply/divide unit and the decoder that drives it.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  function automatic logic is_calc_op(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op[2] == 1'b0) && op[1];
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op[2] == 1'b0) && !op[0];
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// one-cycle sign fixup, and direct HI/LO writes.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO write here
// CALC  | one shift-add / shift-subtract step per cycle, WIDTH cycles
// FIX   | sign fixup and HI/LO write on the edge leaving this state
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     b_q;
  logic                 neg_a_q, neg_b_q, sgn_q, div_q;
  logic [2*WIDTH-1:0]   acc_q;

  logic                 accept, accept_calc, accept_mthi, accept_mtlo;
  logic                 last_step;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       mul_sum, div_trial;
  logic [2*WIDTH-1:0]   mul_next, div_next, prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;
  logic                 b_zero;

  assign accept      = (state_q == ST_IDLE) && start && !flush;
  assign accept_calc = accept && is_calc_op(op);
  assign accept_mthi = accept && (op == OP_MTHI);
  assign accept_mtlo = accept && (op == OP_MTLO);
  assign last_step   = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept_calc) state_d = ST_CALC;
      ST_CALC: begin
        if (flush)          state_d = ST_IDLE;
        else if (last_step) state_d = ST_FIX;
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
  end

  always_comb begin
    abs_a = (is_signed_op(op) && a[WIDTH-1]) ? -a : a;
    abs_b = (is_signed_op(op) && b[WIDTH-1]) ? -b : b;
  end

  // acc holds {partial product} for multiply, {remainder, quotient} for divide.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
    div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                 : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end

  // Divide-by-zero forces an all-ones quotient; the remainder fixup restores hi = a.
  always_comb begin
    b_zero   = (b_q == '0);
    prod_fix = (sgn_q && (neg_a_q ^ neg_b_q)) ? -acc_q : acc_q;
    quo_fix  = b_zero ? '1 :
               ((sgn_q && (neg_a_q ^ neg_b_q)) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    rem_fix  = (sgn_q && neg_a_q) ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      b_q      <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      sgn_q    <= 1'b0;
      div_q    <= 1'b0;
      acc_q    <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept_calc) begin
        acc_q    <= {{WIDTH{1'b0}}, abs_a};
        b_q      <= abs_b;
        neg_a_q  <= is_signed_op(op) && a[WIDTH-1];
        neg_b_q  <= is_signed_op(op) && b[WIDTH-1];
        sgn_q    <= is_signed_op(op);
        div_q    <= is_div_op(op);
        cnt_q    <= '0;
        div_zero <= 1'b0;
      end
      if (accept_mthi) begin
        hi       <= a;
        div_zero <= 1'b0;
      end
      if (accept_mtlo) begin
        lo       <= a;
        div_zero <= 1'b0;
      end
      if (state_q == ST_CALC && !flush) begin
        acc_q <= div_q ? div_next : mul_next;
        cnt_q <= cnt_q + 1'b1;
      end
      if (state_q == ST_FIX && !flush) begin
        if (div_q) begin
          lo <= quo_fix;
          hi <= rem_fix;
        end else begin
          {hi, lo} <= prod_fix;
        end
        done     <= 1'b1;
        div_zero <= div_q && b_zero;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized scoreboard bench for muldiv_unit against a plain-arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           due;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [W-1:0] mdl_hi = '0, mdl_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t ref_model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int ix, iy, q, r;
    longint p;
    logic [63:0] pu;
    e.hi = '0; e.lo = '0; e.dz = 1'b0; e.due = 0;
    ix = x; iy = y;
    case (o)
      3'b000: begin
        p = longint'(ix) * longint'(iy);
        pu = p;
        e.hi = pu[63:32]; e.lo = pu[31:0];
      end
      3'b001: begin
        pu = {32'b0, x} * {32'b0, y};
        e.hi = pu[63:32]; e.lo = pu[31:0];
      end
      3'b010, 3'b011: begin
        if (y == 0) begin
          e.lo = '1; e.hi = x; e.dz = 1'b1;
        end else if (o == 3'b010) begin
          if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            e.lo = 32'h8000_0000; e.hi = '0;
          end else begin
            q = ix / iy; r = ix % iy;
            e.lo = q; e.hi = r;
          end
        end else begin
          e.lo = x / y; e.hi = x % y;
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy still 1 expected 0 (cycle %0d)", cyc);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
    exp_t e;
    wait_idle();
    start = 1'b1; op = o; a = x; b = y;
    if (o[2] == 1'b0 && push) begin
      e = ref_model(o, x, y);
      e.due = cyc + W + 2;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    if (o == OP_MTHI || o == OP_MTLO) begin
      if (o == OP_MTHI) mdl_hi = x; else mdl_lo = x;
      chk("mt_hi", 64'(hi), 64'(mdl_hi));
      chk("mt_lo", 64'(lo), 64'(mdl_lo));
      chk("mt_busy", 64'(busy), 64'(0));
      chk("mt_dz", 64'(div_zero), 64'(0));
    end else if (o[2] == 1'b0) begin
      chk("start_busy", 64'(busy), 64'(1));
    end
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h8000_0000;
      2: return '1;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (done) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: done 1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.due));
          chk("res_hi", 64'(hi), 64'(e.hi));
          chk("res_lo", 64'(lo), 64'(e.lo));
          chk("res_dz", 64'(div_zero), 64'(e.dz));
          mdl_hi = e.hi; mdl_lo = e.lo;
        end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        checks++; errors++;
        $display("FAIL done_timeout: no done by cycle %0d expected at %0d", cyc, sb[0].due);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] ro;
    repeat (3) @(negedge clk);
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_dz", 64'(div_zero), 64'(0));
    rst_n = 1'b1;

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
    issue(OP_DIVU, 32'd100, 32'd0, 1'b1);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd0, 1'b1);
    issue(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b1);

    issue(OP_MTLO, 32'h1234, 32'd0, 1'b1);
    issue(OP_MULTU, 32'd3, 32'd5, 1'b1);
    @(negedge clk);
    start = 1'b1; op = OP_MTLO; a = 32'hBEEF;
    @(negedge clk);
    start = 1'b0;
    chk("mt_busy_ignored_lo", 64'(lo), 64'(32'h1234));
    chk("mt_busy_ignored_busy", 64'(busy), 64'(1));

    wait_idle();
    start = 1'b1; op = 3'b110; a = 32'hABCD;
    @(negedge clk);
    start = 1'b0;
    chk("reserved_busy", 64'(busy), 64'(0));
    chk("reserved_hi", 64'(hi), 64'(mdl_hi));
    chk("reserved_lo", 64'(lo), 64'(mdl_lo));

    start = 1'b1; flush = 1'b1; op = OP_MTHI; a = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_hi", 64'(hi), 64'(mdl_hi));
    chk("flush_start_busy", 64'(busy), 64'(0));

    issue(OP_MULTU, $urandom, $urandom, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'(0));
    chk("flush_hi", 64'(hi), 64'(mdl_hi));
    chk("flush_lo", 64'(lo), 64'(mdl_lo));
    repeat (W + 4) @(negedge clk);
    chk("flush_no_done_hi", 64'(hi), 64'(mdl_hi));

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 5));
      issue(ro, rnd_operand(), rnd_operand(), 1'b1);
    end

    issue(OP_DIV, $urandom, $urandom_range(1, 1000), 1'b0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_hi", 64'(hi), 64'(0));
    chk("midrst_lo", 64'(lo), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_dz", 64'(div_zero), 64'(0));
    mdl_hi = '0; mdl_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(OP_MULTU, 32'd6, 32'd7, 1'b1);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("final_lo", 64'(lo), 64'(42));
    chk("final_hi", 64'(hi), 64'(0));
    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO width; SHALL be even and >= 4.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle request; accepted only when busy=0.
REQ-005 op  input  3  operation, encoded in muldiv_pkg: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are reserved.
REQ-006 a  input  WIDTH  rs operand (multiplicand, dividend, or MTHI/MTLO data).
REQ-007 b  input  WIDTH  rt operand (multiplier or divisor).
REQ-008 flush  input  1  abort any in-flight operation (exception/ERET redirect).
REQ-009 busy  output  1  operation in progress; the pipeline SHALL stall MFHI/MFLO and further muldiv ops while busy=1.
REQ-010 done  output  1  one-cycle pulse; HI/LO hold the new result in this cycle.
REQ-011 hi  output  WIDTH  HI register, driven directly from the register.
REQ-012 lo  output  WIDTH  LO register, driven directly from the register.
REQ-013 div_zero  output  1  sticky flag: the last completed DIV/DIVU had b=0; cleared by the next accepted start.

Function
REQ-014 The FSM SHALL have three states, IDLE, CALC and FIX; busy=1 exactly in CALC and FIX.
REQ-015 In IDLE, start=1 with op MULT/MULTU/DIV/DIVU and flush=0 SHALL latch a and b, then enter CALC with iteration counter = 0.
REQ-016 For signed ops, the unit SHALL latch absolute values of a and b plus sign flags; for unsigned ops it SHALL latch the operands unmodified.
REQ-017 Multiply in CALC: one radix-2 shift-add step per cycle on a 2*WIDTH-bit accumulator, WIDTH cycles in total.
REQ-018 Divide in CALC: one restoring shift-subtract step per cycle, WIDTH cycles in total.
REQ-019 After the WIDTH-th CALC cycle the FSM SHALL enter FIX for exactly one cycle.
REQ-020 FIX, signed multiply: the product SHALL be negated when the operand signs differ.
REQ-021 FIX, signed divide: the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the sign of the dividend.
REQ-022 On the edge ending FIX: multiply SHALL write {hi,lo} = full 2*WIDTH product; divide SHALL write lo = quotient, hi = remainder.
REQ-023 The FSM SHALL then return to IDLE, with done=1 and busy=0 in the following cycle.
REQ-024 Latency: if start is sampled on edge k, done=1 in cycle k+WIDTH+2; busy=1 in cycles k+1 through k+WIDTH+1.
REQ-025 The signed overflow case (most-negative / -1) SHALL give lo = most-negative value and hi = 0, with no exception.
REQ-026 Divide by zero SHALL write lo = all ones and hi = a, and SHALL set div_zero; latency is unchanged.
REQ-027 MTHI/MTLO accepted in IDLE SHALL write hi (or lo) = a on that edge, without entering CALC, asserting busy, or pulsing done.
REQ-028 While busy=1, start SHALL be ignored, including MTHI/MTLO.
REQ-029 Reserved op values SHALL be ignored.
REQ-030 flush=1 in CALC or FIX SHALL return the FSM to IDLE on that edge with hi/lo unchanged and no done pulse.
REQ-031 flush=1 together with start in IDLE: flush wins and start is ignored; flush alone in IDLE has no effect.
REQ-032 The iteration counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL NOT wrap within an operation.

Reset
REQ-033 While rst_n=0, asynchronously: state = IDLE, counter = 0, hi = 0, lo = 0, busy = 0, done = 0, div_zero = 0, internal operand registers = 0.
REQ-034 Reset asserted mid-operation SHALL discard the operation; after release the first accepted start SHALL behave per REQ-015.

Structure
REQ-035 muldiv_pkg SHALL hold the op encodings and FSM state encodings, shared with the decoder that generates start/op.
REQ-036 There is no sub-module; the signed-fixup negation is inline logic.

Verification
REQ-037 WIDTH=32, MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done in cycle k+34; hi=0xFFFFFFFE, lo=0x00000001.
REQ-038 MULT a=-3 (0xFFFFFFFD), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-039 DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100, div_zero=1.
REQ-040 MTLO a=0x1234 in IDLE -> lo=0x1234 next cycle, busy stays 0; the same op issued while busy -> lo unchanged.
REQ-041 Start MULTU, assert flush in CALC cycle 10 -> busy=0 next cycle, no done pulse, hi/lo unchanged.
REQ-042 Start DIV, assert rst_n=0 mid-CALC -> all outputs 0 immediately; after release, MULTU 6x7 -> lo=42, hi=0.
